clk_div_meter: RTL and testbench

- Receive-side counterpart to the team's frequency divider: measures a divided clock, or any slow square wave, in the fast `clk` domain.
- Outputs:
  - high-phase, low-phase and full-period lengths in `clk` cycles;
  - a lock flag once the period is stable;
  - a timeout when the input stops toggling.
- Sits beside divider instances for self-check and ratio readback.

---
 rtl/clk_div_meter_pkg.sv | 23 ++
 rtl/sync_edge_det.sv | 23 ++
 rtl/clk_div_meter.sv | 171 +++++++++++++++++
 tb/tb_clk_div_meter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_meter_pkg.sv
// Shared types and helpers for the clk_div_meter slice.
// Holds the FSM state encoding, the edge-pulse struct and the period-compare helper.
package clk_div_meter_pkg;

  localparam int CW_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACQ   = 2'd1,
    S_TRACK = 2'd2
  } state_e;

  typedef struct packed {
    logic rise;
    logic fall;
  } edge_t;

  // Unsigned distance between two periods; callers zero-extend to 32 bits.
  function automatic logic [31:0] absdiff(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus history flop, producing single-cycle rise/fall pulses.
// Usable by any block that needs clean edges from an asynchronous level.
module sync_edge_det
  import clk_div_meter_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_sig,
  output edge_t o_edge
);

  // r_pipe[0]/[1] are the synchronizer, r_pipe[2] is the history flop.
  logic [2:0] r_pipe;

  always_ff @(posedge clk) begin
    if (rst) r_pipe <= '0;
    else     r_pipe <= {r_pipe[1:0], i_sig};
  end

  assign o_edge.rise = r_pipe[1] & ~r_pipe[2];
  assign o_edge.fall = ~r_pipe[1] & r_pipe[2];

endmodule

// File: rtl/clk_div_meter.sv
// Measures high/low/period of a slow square wave in clk cycles, with lock
// detection on period stability and a timeout when the input stops toggling.
module clk_div_meter
  import clk_div_meter_pkg::*;
#(
  parameter int CW       = CW_DEF,
  parameter int LOCK_CNT = 4,
  parameter int TOL      = 0,
  parameter int TIMEOUT  = 2**CW - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sig_in,
  output logic [CW-1:0] high_time,
  output logic [CW-1:0] low_time,
  output logic [CW:0]   period,
  output logic          meas_valid,
  output logic          period_valid,
  output logic          locked,
  output logic          timeout
);

  localparam int            MW   = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);
  localparam logic [MW-1:0] LC_V = MW'(LOCK_CNT);

  edge_t          w_edges;
  logic           w_rise;
  logic           w_fall;
  logic           w_edge;
  logic           w_run_max;
  logic           w_meas;
  logic           w_to;
  logic           w_per_upd;
  logic [CW:0]    w_per_new;
  logic [31:0]    w_diff;
  logic           w_match;
  logic [MW-1:0]  w_mcnt_nxt;

  state_e         r_state;
  state_e         w_state_nxt;
  logic [CW-1:0]  r_run;
  logic           r_got_hi;
  logic           r_got_lo;
  logic           r_have_ref;
  logic [CW:0]    r_ref;
  logic [MW-1:0]  r_mcnt;
  logic [CW-1:0]  r_high;
  logic [CW-1:0]  r_low;
  logic [CW:0]    r_period;
  logic           r_meas_vld;
  logic           r_per_vld;
  logic           r_locked;
  logic           r_timeout;

  sync_edge_det u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (sig_in),
    .o_edge (w_edges)
  );

  assign w_rise    = w_edges.rise;
  assign w_fall    = w_edges.fall;
  assign w_edge    = w_rise | w_fall;
  assign w_run_max = (r_run == TO_V);

  // An edge on the saturating cycle is a valid capture, so it masks the timeout.
  assign w_meas    = w_edge && (r_state != S_IDLE);
  assign w_to      = !w_edge && w_run_max && (r_state != S_IDLE);
  assign w_per_upd = w_rise && (r_state == S_TRACK);

  assign w_per_new = {1'b0, r_high} + {1'b0, r_run};
  assign w_diff    = absdiff(32'(w_per_new), 32'(r_ref));
  assign w_match   = r_have_ref && (w_diff <= 32'(TOL));

  always_comb begin
    w_mcnt_nxt = '0;
    if (w_match) begin
      if (r_mcnt == LC_V) w_mcnt_nxt = r_mcnt;
      else                w_mcnt_nxt = r_mcnt + MW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_edge) w_state_nxt = S_ACQ;
      end
      S_ACQ: begin
        if (w_edge) begin
          if ((r_got_hi || w_fall) && (r_got_lo || w_rise)) w_state_nxt = S_TRACK;
        end else if (w_run_max) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_TRACK: begin
        if (w_to) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run      <= '0;
      r_got_hi   <= 1'b0;
      r_got_lo   <= 1'b0;
      r_have_ref <= 1'b0;
      r_ref      <= '0;
      r_mcnt     <= '0;
      r_high     <= '0;
      r_low      <= '0;
      r_period   <= '0;
      r_meas_vld <= 1'b0;
      r_per_vld  <= 1'b0;
      r_locked   <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_meas_vld <= w_meas;
      r_per_vld  <= w_per_upd;
      r_timeout  <= w_to;

      if (w_edge)          r_run <= CW'(1);
      else if (!w_run_max) r_run <= r_run + CW'(1);

      // Phase-captured flags only matter during acquisition; clear them elsewhere.
      if (r_state == S_ACQ) begin
        if (w_fall) r_got_hi <= 1'b1;
        if (w_rise) r_got_lo <= 1'b1;
      end else begin
        r_got_hi <= 1'b0;
        r_got_lo <= 1'b0;
      end

      if (w_meas && w_fall) r_high <= r_run;
      if (w_meas && w_rise) r_low  <= r_run;

      if (w_to) begin
        r_have_ref <= 1'b0;
        r_mcnt     <= '0;
        r_locked   <= 1'b0;
      end else if (w_per_upd) begin
        r_period   <= w_per_new;
        r_ref      <= w_per_new;
        r_have_ref <= 1'b1;
        r_mcnt     <= w_mcnt_nxt;
        r_locked   <= (w_mcnt_nxt == LC_V);
      end else if (r_state != S_TRACK) begin
        // First period after entering tracking only seeds the reference.
        r_have_ref <= 1'b0;
        r_mcnt     <= '0;
      end
    end
  end

  assign high_time    = r_high;
  assign low_time     = r_low;
  assign period       = r_period;
  assign meas_valid   = r_meas_vld;
  assign period_valid = r_per_vld;
  assign locked       = r_locked;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_clk_div_meter.sv
// Directed bench for clk_div_meter: hand-derived expectations queued per segment,
// popped and compared whenever the DUT pulses meas_valid / period_valid.
module tb_clk_div_meter;
  import clk_div_meter_pkg::*;

  localparam int CW = 16;

  typedef struct { int h; int l; } meas_t;
  typedef struct { int p; int lk; } per_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          sig_in;

  logic [CW-1:0] a_high_time, a_low_time, b_high_time, b_low_time;
  logic [CW:0]   a_period, b_period;
  logic          a_meas_valid, a_period_valid, a_locked, a_timeout;
  logic          b_meas_valid, b_period_valid, b_locked, b_timeout;

  int    n_cmp = 0;
  int    n_err = 0;
  int    n_to  = 0;
  int    b_npv = 0;
  logic  b_watch = 1'b0;
  meas_t q_meas[$];
  per_t  q_per[$];

  always #5 clk = ~clk;

  clk_div_meter #(.CW(CW), .LOCK_CNT(4), .TOL(0), .TIMEOUT(20)) dut_a (
    .clk(clk), .rst(rst), .sig_in(sig_in),
    .high_time(a_high_time), .low_time(a_low_time), .period(a_period),
    .meas_valid(a_meas_valid), .period_valid(a_period_valid),
    .locked(a_locked), .timeout(a_timeout)
  );

  clk_div_meter #(.CW(CW), .LOCK_CNT(4), .TOL(1), .TIMEOUT(20)) dut_b (
    .clk(clk), .rst(rst), .sig_in(sig_in),
    .high_time(b_high_time), .low_time(b_low_time), .period(b_period),
    .meas_valid(b_meas_valid), .period_valid(b_period_valid),
    .locked(b_locked), .timeout(b_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_meas(input int h, input int l, input int n);
    meas_t m;
    m.h = h; m.l = l;
    repeat (n) q_meas.push_back(m);
  endtask

  task automatic push_per(input int p, input int lk, input int n);
    per_t e;
    e.p = p; e.lk = lk;
    repeat (n) q_per.push_back(e);
  endtask

  // Drive v and keep it for exactly n clk rising edges.
  task automatic hold(input logic v, input int n);
    sig_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_high"},  32'(a_high_time),    32'd0);
    check({tag, "_low"},   32'(a_low_time),     32'd0);
    check({tag, "_per"},   32'(a_period),       32'd0);
    check({tag, "_mv"},    32'(a_meas_valid),   32'd0);
    check({tag, "_pv"},    32'(a_period_valid), 32'd0);
    check({tag, "_lock"},  32'(a_locked),       32'd0);
    check({tag, "_to"},    32'(a_timeout),      32'd0);
    check({tag, "_state"}, 32'(dut_a.r_state),  32'(S_IDLE));
  endtask

  always @(negedge clk) begin
    meas_t m;
    per_t  e;
    if (!rst) begin
      if (a_meas_valid) begin
        n_cmp++;
        assert (q_meas.size() != 0) else begin
          n_err++;
          $error("FAIL meas_extra: observed pulse with high=%0d low=%0d, expected none", a_high_time, a_low_time);
        end
        if (q_meas.size() != 0) begin
          m = q_meas.pop_front();
          check("high_time", 32'(a_high_time), 32'(m.h));
          check("low_time",  32'(a_low_time),  32'(m.l));
        end
      end
      if (a_period_valid) begin
        n_cmp++;
        assert (q_per.size() != 0) else begin
          n_err++;
          $error("FAIL per_extra: observed pulse with period=%0d, expected none", a_period);
        end
        if (q_per.size() != 0) begin
          e = q_per.pop_front();
          check("period", 32'(a_period), 32'(e.p));
          check("locked", 32'(a_locked), 32'(e.lk));
        end
      end
      if (a_timeout) n_to++;
      if (b_watch && b_period_valid) begin
        b_npv++;
        check("tol1_locked", 32'(b_locked), 32'd1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("rst0");
    rst = 1'b0;
    hold(0, 3);

    // Half-period 5 lock, then 5/6 transition period 11 and re-lock at 12.
    push_meas(5, 0, 1); push_meas(5, 5, 12); push_meas(5, 6, 1); push_meas(6, 6, 10);
    push_per(10, 0, 4); push_per(10, 1, 1); push_per(11, 0, 1); push_per(12, 0, 4); push_per(12, 1, 1);
    repeat (6) begin hold(1, 5); hold(0, 5); end
    b_watch = 1'b1;
    hold(1, 5); hold(0, 6);
    repeat (5) begin hold(1, 6); hold(0, 6); end

    // Stall high after lock: single timeout 20 cycles after the last edge.
    sig_in = 1'b1;
    repeat (22) @(negedge clk);
    check("to_early", 32'(a_timeout), 32'd0);
    @(negedge clk);
    check("to_pulse",  32'(a_timeout),     32'd1);
    check("to_locked", 32'(a_locked),      32'd0);
    check("to_state",  32'(dut_a.r_state), 32'(S_IDLE));
    check("to_high",   32'(a_high_time),   32'd6);
    check("to_low",    32'(a_low_time),    32'd6);
    check("to_per",    32'(a_period),      32'd12);
    @(negedge clk);
    check("to_once", 32'(a_timeout), 32'd0);
    b_watch = 1'b0;
    repeat (10) @(negedge clk);
    check("to_count", 32'(n_to),  32'd1);
    check("tol1_cnt", 32'(b_npv), 32'd7);

    // Restart with 3/7 duty; first edge silent, then 3-edge rise latency.
    push_meas(6, 7, 1); push_meas(3, 7, 6); push_per(10, 0, 3);
    hold(0, 7);
    repeat (3) begin hold(1, 3); hold(0, 7); end
    sig_in = 1'b1;
    repeat (2) @(negedge clk);
    check("lat_2", 32'(a_meas_valid), 32'd0);
    @(negedge clk);
    check("lat_3_mv", 32'(a_meas_valid),   32'd1);
    check("lat_3_pv", 32'(a_period_valid), 32'd1);

    // Toggle every clk: 1/1/2 and lock.
    push_meas(3, 7, 1); push_meas(3, 1, 1); push_meas(1, 1, 12);
    push_per(4, 0, 1); push_per(2, 0, 4); push_per(2, 1, 2);
    hold(0, 1); hold(1, 1);
    repeat (5) begin hold(0, 1); hold(1, 1); end
    hold(0, 1);

    // Phases of exactly TIMEOUT: captured as 20, no timeout.
    push_meas(20, 1, 1); push_meas(20, 20, 1); push_per(40, 0, 1);
    hold(1, 20); hold(0, 20);

    // Half-period 4 re-lock, then reset mid-high-phase.
    push_meas(4, 20, 1); push_meas(4, 4, 9); push_per(8, 0, 4); push_per(8, 1, 1);
    hold(1, 4); hold(0, 4);
    repeat (4) begin hold(1, 4); hold(0, 4); end
    sig_in = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_rst_lock", 32'(a_locked), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst1");
    rst = 1'b0;
    hold(0, 4);

    // Cold re-acquisition: no stale low_time or period.
    push_meas(5, 0, 1); push_meas(5, 5, 6); push_per(10, 0, 2);
    repeat (4) begin hold(1, 5); hold(0, 5); end
    repeat (5) @(negedge clk);

    check("meas_drain", 32'(q_meas.size()), 32'd0);
    check("per_drain",  32'(q_per.size()),  32'd0);
    check("to_total",   32'(n_to),          32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
